// File: rtl/aes_io_pkg.sv
// Shared constants for the AES result readout path: UART defaults, frame
// geometry, serialiser state encoding and the frame byte selector.
package aes_io_pkg;

   localparam int         DEFAULT_CLK_DIV  = 174;
   localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;
   localparam int         FRAME_LEN        = 33;
   localparam int         BYTE_IDX_W       = 6;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_START_BIT = 2'd1;
   localparam logic [1:0] ST_DATA      = 2'd2;
   localparam logic [1:0] ST_STOP      = 2'd3;

   // {state, cipherkey} as captured at frame start
   typedef logic [255:0] shadow_t;

   // Byte 0 is the header; bytes 1..32 walk the shadow from its MSB down.
   function automatic logic [7:0] frame_byte(input shadow_t                blk,
                                             input logic [BYTE_IDX_W-1:0] idx,
                                             input logic [7:0]            hdr);
      shadow_t sh;
      if (idx == '0 || idx >= BYTE_IDX_W'(FRAME_LEN)) begin
         return hdr;
      end
      sh = blk >> (8 * (FRAME_LEN - 1 - int'(idx)));
      return sh[7:0];
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for one byte; a load on the byte_done cycle chains the next
// byte with no idle gap.
//   state        | meaning
//   ST_IDLE      | line idle high, waiting for load
//   ST_START_BIT | driving the low start bit
//   ST_DATA      | shifting out 8 data bits, LSB first
//   ST_STOP      | driving the high stop bit
module uart_tx_byte
   import aes_io_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       txd,
   output logic       byte_done
);

   localparam int               CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_txd;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);
   assign byte_done  = (r_state == ST_STOP) && w_cnt_zero;
   assign txd        = r_txd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
      end else if (load) begin
         r_state   <= ST_START_BIT;
         r_cnt     <= CNT_LOAD;
         r_bit_idx <= '0;
         r_shift   <= data;
         r_txd     <= 1'b0;
      end else begin
         case (r_state)
            ST_START_BIT: begin
               if (w_cnt_zero) begin
                  r_state <= ST_DATA;
                  r_cnt   <= CNT_LOAD;
                  r_txd   <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (w_cnt_zero) begin
                  r_cnt <= CNT_LOAD;
                  if (r_bit_idx == 3'd7) begin
                     r_state   <= ST_STOP;
                     r_bit_idx <= '0;
                     r_txd     <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_txd     <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               if (w_cnt_zero) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/result_uart_tx.sv
// Sends one 33-byte result frame (header, AES state, AES key) over UART.
// Owns capture, byte sequencing and the ready/busy/done handshake.
module result_uart_tx
   import aes_io_pkg::*;
#(
   parameter int         CLK_DIV  = DEFAULT_CLK_DIV,
   parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] state,
   input  logic [127:0] cipherkey,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic         txd
);

   shadow_t               r_shadow;
   logic [BYTE_IDX_W-1:0] r_byte_idx;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_accept;
   logic                  w_byte_done;
   logic                  w_last;
   logic                  w_load;
   logic [BYTE_IDX_W-1:0] w_next_idx;
   logic [7:0]            w_data;

   assign w_accept   = start && !r_busy;
   assign w_last     = w_byte_done && (r_byte_idx == BYTE_IDX_W'(FRAME_LEN - 1));
   assign w_load     = w_accept || (w_byte_done && !w_last);
   assign w_next_idx = r_byte_idx + 1'b1;
   // Header is sent straight from the parameter so it can leave on the accept edge
   assign w_data     = w_accept ? HDR_BYTE : frame_byte(r_shadow, w_next_idx, HDR_BYTE);

   assign ready = !r_busy;
   assign busy  = r_busy;
   assign done  = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow   <= '0;
         r_byte_idx <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_shadow   <= {state, cipherkey};
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
         end else if (w_last) begin
            r_byte_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
         end else if (w_byte_done) begin
            r_byte_idx <= w_next_idx;
         end
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx_byte (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load),
      .data      (w_data),
      .txd       (txd),
      .byte_done (w_byte_done)
   );

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: an independent UART receiver decodes txd and the
// decoded bytes/timing are compared against a frame built from the inputs.
module tb_result_uart_tx;

   localparam int         CLK_DIV   = 4;
   localparam logic [7:0] HDR       = 8'hA5;
   localparam int         FRAME_CYC = 330 * CLK_DIV;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] st = '0;
   logic [127:0] ck = '0;
   logic         ready, busy, done, txd;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int rst_seen = 0;
   int fr_err = 0;
   int inv_err = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         done_t[$];
   logic [7:0] exp_q[$];

   always #25 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_seen++;
   always @(negedge clk) if (done === 1'b1) done_t.push_back(cyc);
   always @(negedge clk) if (busy !== ~ready) inv_err++;

   result_uart_tx #(
      .CLK_DIV  (CLK_DIV),
      .HDR_BYTE (HDR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .state     (st),
      .cipherkey (ck),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .txd       (txd)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Receiver: finds the start bit, then samples each bit at its centre.
   initial begin : uart_mon
      logic [7:0] b;
      bit         bad;
      int         t0;
      int         rs0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txd === 1'b0) begin
            t0  = cyc;
            rs0 = rst_seen;
            bad = 0;
            repeat (CLK_DIV / 2) @(negedge clk);
            if (txd !== 1'b0) bad = 1;
            for (int k = 0; k < 8; k++) begin
               repeat (CLK_DIV) @(negedge clk);
               b[k] = txd;
            end
            repeat (CLK_DIV) @(negedge clk);
            if (txd !== 1'b1) bad = 1;
            if (rst_seen == rs0) begin
               if (bad) fr_err++;
               rx_q.push_back(b);
               rx_t.push_back(t0);
            end
         end
      end
   end

   task automatic add_frame(input logic [127:0] s, input logic [127:0] k);
      exp_q.push_back(HDR);
      for (int i = 15; i >= 0; i--) exp_q.push_back(s[8*i +: 8]);
      for (int i = 15; i >= 0; i--) exp_q.push_back(k[8*i +: 8]);
   endtask

   task automatic clear_all();
      rx_q.delete();
      rx_t.delete();
      done_t.delete();
      exp_q.delete();
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 4000 && done_t.size() < target; i++) @(negedge clk);
      check_val("done_count", done_t.size(), target);
   endtask

   task automatic compare_bytes(input string tag);
      int n;
      check_val({tag, "_nbytes"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_val($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin : watchdog
      #(50 * 60000);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [127:0] sa, ka, sb, kb;
      int           early_ready;

      // reset
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_txd", txd, 1);
      check_val("rst_ready", ready, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // reference vector frame
      clear_all();
      st = 128'h3925841D02DC09FBDC118597196A0B32;
      ck = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
      add_frame(st, ck);
      pulse_start();
      wait_done(1);
      repeat (60) @(negedge clk);
      compare_bytes("ref");
      if (rx_t.size() > 0 && done_t.size() > 0)
         check_val("ref_latency", done_t[0] - rx_t[0], FRAME_CYC);

      // random frames, input changed mid-frame
      for (int f = 0; f < 2; f++) begin
         clear_all();
         st = rnd128();
         ck = rnd128();
         add_frame(st, ck);
         pulse_start();
         repeat (9) @(negedge clk);
         st = '1;
         ck = ~ck;
         wait_done(1);
         repeat (60) @(negedge clk);
         compare_bytes($sformatf("chg%0d", f));
         if (rx_t.size() > 0 && done_t.size() > 0)
            check_val("chg_latency", done_t[0] - rx_t[0], FRAME_CYC);
      end

      // start while busy
      clear_all();
      st = rnd128();
      ck = rnd128();
      add_frame(st, ck);
      pulse_start();
      repeat (499) @(negedge clk);
      start = 1'b1;
      check_val("busy_ready", ready, 0);
      @(negedge clk);
      start = 1'b0;
      early_ready = 0;
      for (int i = 0; i < 4000 && done_t.size() < 1; i++) begin
         if (ready === 1'b1 && done !== 1'b1) early_ready++;
         @(negedge clk);
      end
      check_val("busy_done_count", done_t.size(), 1);
      check_val("busy_early_ready", early_ready, 0);
      repeat (2 * FRAME_CYC / 10) @(negedge clk);
      check_val("busy_done_total", done_t.size(), 1);
      compare_bytes("busy");

      // back-to-back with start held; inputs re-captured for frame two
      clear_all();
      sa = rnd128();
      ka = rnd128();
      sb = rnd128();
      kb = rnd128();
      st = sa;
      ck = ka;
      add_frame(sa, ka);
      add_frame(sb, kb);
      start = 1'b1;
      repeat (10) @(negedge clk);
      st = sb;
      ck = kb;
      wait_done(1);
      @(negedge clk);
      start = 1'b0;
      wait_done(2);
      repeat (60) @(negedge clk);
      compare_bytes("b2b");
      if (rx_t.size() > 33 && done_t.size() > 1) begin
         check_val("b2b_gap", rx_t[33] - done_t[0], 1);
         check_val("b2b_frame2", done_t[1] - rx_t[33], FRAME_CYC);
         check_val("b2b_total", (done_t[0] - rx_t[0]) + (done_t[1] - rx_t[33]), 2 * FRAME_CYC);
      end

      // reset mid-frame while txd is low
      clear_all();
      st = rnd128();
      ck = rnd128();
      pulse_start();
      repeat (700) @(negedge clk);
      for (int i = 0; i < 40 && txd !== 1'b0; i++) @(negedge clk);
      check_val("pre_rst_txd", txd, 0);
      #5 rst_n = 1'b0;
      #1;
      check_val("mid_rst_txd", txd, 1);
      check_val("mid_rst_ready", ready, 1);
      check_val("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check_val("post_rst_idle_txd", txd, 1);
      check_val("post_rst_no_done", done_t.size(), 0);
      clear_all();
      st = rnd128();
      ck = rnd128();
      add_frame(st, ck);
      pulse_start();
      wait_done(1);
      repeat (60) @(negedge clk);
      compare_bytes("rst");
      if (rx_t.size() > 0 && done_t.size() > 0)
         check_val("rst_latency", done_t[0] - rx_t[0], FRAME_CYC);

      check_val("framing_errors", fr_err, 0);
      check_val("busy_not_ready", inv_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 174, clock cycles per UART bit (20 MHz / 115200); legal range 2..65535.
REQ-002 Parameter HDR_BYTE, default 8'hA5, frame header byte.
REQ-003 clk  input  1  system clock; all logic on rising edge, single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to transmit one frame; sampled only when ready=1.
REQ-006 state  input  128  AES result block from the core.
REQ-007 cipherkey  input  128  AES key from the core.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 busy  output  1  high while a frame is in progress; always equals ~ready.
REQ-010 done  output  1  one-cycle pulse when the final stop bit completes.
REQ-011 txd  output  1  UART serial line, 8N1, LSB first, idle high.

Function
REQ-012 The frame SHALL be 33 bytes: HDR_BYTE, then state[127:120] down to state[7:0], then cipherkey[127:120] down to cipherkey[7:0].
REQ-013 On a clock edge with start=1 and ready=1, state and cipherkey SHALL be captured into a 256-bit shadow register; later input changes SHALL NOT affect the frame in progress.
REQ-014 FSM states SHALL be IDLE, START_BIT, DATA, STOP; transitions: IDLE->START_BIT on accepted start; START_BIT->DATA after CLK_DIV cycles; DATA->STOP after 8 bits; STOP->START_BIT if bytes remain, STOP->IDLE after byte 33.
REQ-015 txd SHALL go low in the cycle after start is accepted, and every bit SHALL last exactly CLK_DIV cycles.
REQ-016 No idle gap SHALL separate bytes; one full frame SHALL last exactly 330*CLK_DIV cycles from the first start-bit cycle to the end of the last stop bit.
REQ-017 done SHALL be high for exactly one cycle, the cycle in which the FSM returns to IDLE; ready SHALL be 1 in that same cycle.
REQ-018 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 start held high continuously SHALL produce back-to-back frames, with the next frame accepted in the cycle done is asserted and state/cipherkey re-captured at that edge.
REQ-020 The bit-period counter SHALL be wide enough for CLK_DIV-1; the bit index SHALL be 3 bits; the byte index SHALL be 6 bits and SHALL wrap to 0 on return to IDLE.

Reset
REQ-021 While rst_n=0: FSM=IDLE, txd=1, ready=1, busy=0, done=0, all counters=0, shadow register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously forcing txd high, with no partial-byte completion.
REQ-023 After rst_n deasserts, the first accepted start SHALL begin a fresh frame at the header byte.

Structure
REQ-024 CLK_DIV default, HDR_BYTE default, frame length (33) and the FSM state encoding SHALL live in a shared package, aes_io_pkg.
REQ-025 A single sub-module uart_tx_byte SHALL serialise one byte (ports clk, rst_n, load, data[7:0], txd, byte_done); result_uart_tx SHALL own the frame sequencing and byte selection.

Verification (bench: CLK_DIV=4, clk period 50 ns)
REQ-026 Reset: hold rst_n=0 for 2 cycles -> txd=1, ready=1, busy=0, done=0.
REQ-027 Single frame: state=128'h3925841D02DC09FBDC118597196A0B32, cipherkey=128'h2B7E151628AED2A6ABF7158809CF4F3C, one-cycle start -> UART decoder reads A5,39,25,...,32,2B,7E,...,3C; done pulses exactly 1320 cycles after txd first falls.
REQ-028 Input change mid-frame: change state to all-ones 10 cycles after start -> transmitted bytes still match the captured values.
REQ-029 Start while busy: pulse start at cycle 500 of a frame -> no effect; exactly one frame is sent; ready stays 0 until done.
REQ-030 Back-to-back: hold start=1 for two frames -> second header start bit begins in the cycle after done; no gap; 2640 cycles in total.
REQ-031 Reset mid-frame: assert rst_n=0 at cycle 700 -> txd=1 within the same cycle; after release plus start, a complete frame begins with A5.
